sprite_mover: RTL and testbench
===============================

# sprite_mover

Parametrised sprite engine sitting between the movement/input logic and `vga_adapter` in the DuckHunt design. On each frame tick it erases a rectangular sprite at its old position, applies a clamped multi-pixel move from a 4-bit direction vector, and redraws the sprite at the new position. It emits one pixel write per cycle on the adapter's `x`/`y`/`colour`/`plot` port. It generalises the fixed single-pixel mover to arbitrary sprite size, screen size, step and colours, and adds boundary clamping, a busy/done handshake and a no-move skip.

## Interface
- `SCREEN_W`, 160, screen width in pixels
- `SCREEN_H`, 120, screen height in pixels
- `X_W`, 8, x coordinate width
- `Y_W`, 7, y coordinate width
- `SPR_W`, 4, sprite width (1..SCREEN_W)
- `SPR_H`, 4, sprite height (1..SCREEN_H)
- `STEP`, 1, pixels moved per tick per axis
- `COLOUR_W`, 3, colour width
- `FG_COLOUR`, 3'b111, sprite colour
- `BG_COLOUR`, 3'b000, erase colour
- `X0`, 0, reset x position (top-left corner)
- `Y0`, 0, reset y position (top-left corner)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `tick`  in  1  one-cycle frame enable (from RateDivider)
- `move`  in  4  direction vector {up, down, left, right}, sampled only on an accepted tick
- `x`  out  X_W  pixel x to vga_adapter
- `y`  out  Y_W  pixel y to vga_adapter
- `colour`  out  COLOUR_W  pixel colour
- `plot`  out  1  pixel write strobe
- `pos_x`  out  X_W  current sprite top-left x
- `pos_y`  out  Y_W  current sprite top-left y
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a pass completes

## Operation
- States: INIT, IDLE, ERASE, UPDATE, DRAW, DONE.
- Reset (async):
  - state=INIT, pos=(X0,Y0).
  - x=0, y=0, colour=BG_COLOUR, plot=0, done=0, busy=1.
- INIT:
  - Draws the sprite at (X0,Y0) in FG_COLOUR.
  - Then goes to DONE, then IDLE.
- IDLE, tick=1, move≠0: latch `move`, go to ERASE.
- IDLE, tick=1, move=0: go straight to DONE. No pixels are written.
- IDLE, tick=0: stay in IDLE.
- Tick while busy: ignored, not queued.
- ERASE / DRAW:
  - Scan SPR_W×SPR_H offsets in row-major order (column inner, row outer).
  - One write per cycle: x=pos_x+col, y=pos_y+row.
  - Colour is BG_COLOUR in ERASE and FG_COLOUR in DRAW.
- UPDATE (one cycle, plot=0): dx = right−left, dy = down−up.
  - Opposing bits cancel on that axis.
  - Each moving axis moves STEP pixels, saturating to [0, SCREEN_W−SPR_W] for x and [0, SCREEN_H−SPR_H] for y.
  - Arithmetic uses X_W+1 / Y_W+1 bit signed intermediates, so no wrap-around occurs.
- If the clamped position equals the old position, DRAW still runs and repaints in place.
- DONE: done=1 for one cycle, then IDLE.
- `pos_x`/`pos_y` change only at the UPDATE→DRAW edge.

## Timing
- N = SPR_W·SPR_H.
- `x`, `y`, `colour`, `plot` are registered and change together.
- `plot` is high for exactly N consecutive cycles per ERASE or DRAW pass, and never between passes.
- Tick accepted at edge t:
  - Erase writes occupy cycles t+1..t+N.
  - UPDATE is cycle t+N+1.
  - Draw writes occupy t+N+2..t+2N+1.
  - done is high in cycle t+2N+2.
  - busy falls at t+2N+3.
- Accepted tick with move=0: done is high in cycle t+1.
- After reset release: N draw cycles, then done, then IDLE.
- Reset mid-pass: everything returns to reset values immediately. The half-drawn frame is not cleaned; INIT redraws at (X0,Y0).

## Structure
- Package `sprite_pkg`:
  - state enum
  - direction bit indices (UP=3, DOWN=2, LEFT=1, RIGHT=0)
  - localparams X_MAX = SCREEN_W−SPR_W and Y_MAX = SCREEN_H−SPR_H
- Sub-module `pixel_scanner`:
  - Parametrised col/row offset counter with `start`, `en`, `col`, `row` and `last` outputs.
  - Instantiated once and shared by INIT, ERASE and DRAW.
- Top FSM and position registers live in `sprite_mover`.

## Test plan
- Reset with defaults:
  - Exactly 16 plot cycles follow, covering (0..3, 0..3) in FG 3'b111, row-major.
  - Then done pulses; pos=(0,0), busy=0.
- tick with move=4'b0001 at pos (0,0):
  - 16 BG writes at (0..3, 0..3), one idle cycle, then 16 FG writes at (1..4, 0..3).
  - done arrives 34 cycles after tick; pos=(1,0).
- Set STEP=5, pos=(154,0), move=right:
  - pos clamps to 156 = 160−4.
  - With pos already at 156, right gives erase plus redraw at 156.
- move=4'b1100 (up+down) at pos (10,10):
  - pos stays (10,10); erase and redraw both occur.
- move=0 on tick:
  - No plot; done in the next cycle.
  - A second tick during a 34-cycle pass is ignored (pos moves once).
- Assert reset in cycle 8 of DRAW:
  - plot=0 and pos=(X0,Y0) immediately.
  - After release, a full 16-cycle INIT draw runs.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine: FSM encodings, direction bit
// indices and the default screen geometry.
package sprite_pkg;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ERASE  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DRAW   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    INIT   = ST_INIT,
    IDLE   = ST_IDLE,
    ERASE  = ST_ERASE,
    UPDATE = ST_UPDATE,
    DRAW   = ST_DRAW,
    DONE   = ST_DONE
  } state_t;

  localparam int unsigned UP    = 3;
  localparam int unsigned DOWN  = 2;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 0;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;
  localparam int unsigned SPR_W_DEF    = 4;
  localparam int unsigned SPR_H_DEF    = 4;
  localparam int unsigned X_MAX        = SCREEN_W_DEF - SPR_W_DEF;
  localparam int unsigned Y_MAX        = SCREEN_H_DEF - SPR_H_DEF;

endpackage

// File: rtl/pixel_scanner.sv
// Row-major sprite offset counter: col runs inner, row outer, and wraps to
// (0,0) after the last offset so the next pass starts clean.
module pixel_scanner #(
  parameter int unsigned COLS = 4,
  parameter int unsigned ROWS = 4,
  parameter int unsigned CW   = 8,
  parameter int unsigned RW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(COLS - 1));
  assign row_end = (row == RW'(ROWS - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Frame-tick sprite engine: erases the sprite, applies a clamped move and
// redraws it, emitting one registered pixel write per cycle.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int unsigned         SCREEN_W  = 160,
  parameter int unsigned         SCREEN_H  = 120,
  parameter int unsigned         X_W       = 8,
  parameter int unsigned         Y_W       = 7,
  parameter int unsigned         SPR_W     = 4,
  parameter int unsigned         SPR_H     = 4,
  parameter int unsigned         STEP      = 1,
  parameter int unsigned         COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000,
  parameter int unsigned         X0        = 0,
  parameter int unsigned         Y0        = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [3:0]          move,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y,
  output logic                busy,
  output logic                done
);

  localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(SCREEN_W - SPR_W);
  localparam logic signed [Y_W:0] YMAX_S = (Y_W+1)'(SCREEN_H - SPR_H);
  localparam logic signed [X_W:0] STEP_X = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] STEP_Y = (Y_W+1)'(STEP);

  state_t            state;
  logic              fin;
  logic [3:0]        mv;
  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;
  logic              last;
  logic              scanning;
  logic              accept_move;
  logic              en;
  logic              start;
  logic signed [X_W:0] nx;
  logic signed [Y_W:0] ny;

  assign scanning    = (state == INIT) || (state == ERASE) || (state == DRAW);
  assign accept_move = (state == IDLE) && tick && (move != '0);
  // The scanner leads the outputs: each advance corresponds to the pixel
  // registered on the same edge; fin marks that the last one is on the bus.
  assign en          = (scanning && !fin) || (state == UPDATE) || accept_move;
  assign start       = scanning && fin;

  pixel_scanner #(
    .COLS (SPR_W),
    .ROWS (SPR_H),
    .CW   (X_W),
    .RW   (Y_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .en    (en),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_comb begin
    nx = signed'({1'b0, pos_x});
    ny = signed'({1'b0, pos_y});
    if (mv[RIGHT] && !mv[LEFT])      nx = nx + STEP_X;
    else if (mv[LEFT] && !mv[RIGHT]) nx = nx - STEP_X;
    if (mv[DOWN] && !mv[UP])         ny = ny + STEP_Y;
    else if (mv[UP] && !mv[DOWN])    ny = ny - STEP_Y;
    if (nx[X_W])                     nx = '0;
    else if (nx > XMAX_S)            nx = XMAX_S;
    if (ny[Y_W])                     ny = '0;
    else if (ny > YMAX_S)            ny = YMAX_S;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      pos_x  <= X_W'(X0);
      pos_y  <= Y_W'(Y0);
      x      <= '0;
      y      <= '0;
      colour <= BG_COLOUR;
      plot   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b1;
      fin    <= 1'b0;
      mv     <= '0;
    end else begin
      case (state)
        INIT, ERASE, DRAW: begin
          if (fin) begin
            fin   <= 1'b0;
            plot  <= 1'b0;
            state <= (state == ERASE) ? UPDATE : DONE;
            done  <= (state != ERASE);
          end else begin
            plot   <= 1'b1;
            x      <= pos_x + col;
            y      <= pos_y + row;
            colour <= (state == ERASE) ? BG_COLOUR : FG_COLOUR;
            fin    <= last;
          end
        end
        UPDATE: begin
          pos_x  <= nx[X_W-1:0];
          pos_y  <= ny[Y_W-1:0];
          plot   <= 1'b1;
          x      <= nx[X_W-1:0] + col;
          y      <= ny[Y_W-1:0] + row;
          colour <= FG_COLOUR;
          fin    <= last;
          state  <= DRAW;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          if (accept_move) begin
            mv     <= move;
            busy   <= 1'b1;
            plot   <= 1'b1;
            x      <= pos_x + col;
            y      <= pos_y + row;
            colour <= BG_COLOUR;
            fin    <= last;
            state  <= ERASE;
          end else if (tick) begin
            busy  <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: default geometry plus a STEP=5 instance
// started near the right edge.
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, tick2;
  logic [3:0] move, move2;

  logic [7:0] x, pos_x, x2, pos_x2;
  logic [6:0] y, pos_y, y2, pos_y2;
  logic [2:0] colour, colour2;
  logic       plot, busy, done, plot2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_mover dut (
    .clk(clk), .reset(reset), .tick(tick), .move(move),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done)
  );

  sprite_mover #(.STEP(5), .X0(154)) dut2 (
    .clk(clk), .reset(reset), .tick(tick2), .move(move2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2),
    .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic px(input string tag, input logic p, input logic [2:0] c,
                    input int xx, input int yy);
    check(tag, 32'({plot, colour, x, y}), 32'({p, c, 8'(xx), 7'(yy)}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_draw();
    for (int i = 0; i < 16; i++) begin
      px("init_pix", 1'b1, 3'b111, i % 4, i / 4);
      step();
    end
    check("init_done", 32'({done, plot, busy}), 32'(3'b101));
    step();
    check("init_idle", 32'({done, busy, pos_x, pos_y}), 32'd0);
  endtask

  task automatic pass(input logic [3:0] mv, input int ox, input int oy,
                      input int nx, input int ny, input bit extra);
    tick = 1'b1; move = mv;
    step();
    tick = 1'b0; move = '0;
    for (int i = 0; i < 16; i++) begin
      px("erase_pix", 1'b1, 3'b000, ox + i % 4, oy + i / 4);
      if (extra && i == 5) begin
        tick = 1'b1; move = 4'b0001;
      end
      step();
      tick = 1'b0; move = '0;
    end
    check("update", 32'({plot, done, pos_x, pos_y}), 32'({2'b00, 8'(ox), 7'(oy)}));
    step();
    for (int i = 0; i < 16; i++) begin
      px("draw_pix", 1'b1, 3'b111, nx + i % 4, ny + i / 4);
      step();
    end
    check("pass_done", 32'({done, plot, busy, pos_x, pos_y}), 32'({3'b101, 8'(nx), 7'(ny)}));
    step();
    check("pass_idle", 32'({done, busy}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; tick2 = 1'b0; move = '0; move2 = '0;
    step(); step();
    check("rst_out", 32'({plot, done, busy, colour, x, y}), 32'({3'b001, 3'b000, 8'd0, 7'd0}));
    check("rst_pos", 32'({pos_x, pos_y}), 32'd0);
    check("rst_pos2", 32'(pos_x2), 32'd154);
    reset = 1'b0;
    step();
    init_draw();

    // STEP=5 instance: clamp at the right edge, then repaint in place
    tick2 = 1'b1; move2 = 4'b0001;
    step();
    tick2 = 1'b0; move2 = '0;
    check("clamp_erase", 32'({plot2, colour2, x2, y2}), 32'({1'b1, 3'b000, 8'd154, 7'd0}));
    repeat (33) step();
    check("clamp_done", 32'({done2, pos_x2, pos_y2}), 32'({1'b1, 8'd156, 7'd0}));
    step();
    tick2 = 1'b1; move2 = 4'b0001;
    step();
    tick2 = 1'b0; move2 = '0;
    check("edge_erase", 32'({plot2, colour2, x2}), 32'({1'b1, 3'b000, 8'd156}));
    repeat (16) step();
    check("edge_update", 32'(plot2), 32'd0);
    step();
    check("edge_draw", 32'({plot2, colour2, x2}), 32'({1'b1, 3'b111, 8'd156}));
    repeat (16) step();
    check("edge_done", 32'({done2, pos_x2}), 32'({1'b1, 8'd156}));
    step();

    pass(4'b1000, 0, 0, 0, 0, 1'b0);
    pass(4'b0001, 0, 0, 1, 0, 1'b1);

    tick = 1'b1; move = '0;
    step();
    tick = 1'b0;
    check("nomove_done", 32'({done, plot, busy}), 32'(3'b101));
    step();
    check("nomove_idle", 32'({done, plot, busy, pos_x, pos_y}), 32'({3'b000, 8'd1, 7'd0}));

    for (int k = 0; k < 9; k++) pass(4'b0101, 1 + k, k, 2 + k, 1 + k, 1'b0);
    pass(4'b0100, 10, 9, 10, 10, 1'b0);
    pass(4'b1100, 10, 10, 10, 10, 1'b0);

    tick = 1'b1; move = 4'b0001;
    step();
    tick = 1'b0; move = '0;
    repeat (24) step();
    px("mid_draw", 1'b1, 3'b111, 14, 11);
    reset = 1'b1;
    #1;
    check("mid_reset", 32'({plot, done, busy, pos_x, pos_y}), 32'({3'b001, 8'd0, 7'd0}));
    step();
    reset = 1'b0;
    step();
    init_draw();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
